// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_pkg
//  Purpose  : Shared constants and state encoding for the round-robin memory
//             arbiter (mem_rr_arbiter) and its picker (rr_pick4).
//  Contents : NREQ, REQ_IDX_W, TIMEOUT_DEFAULT, arb_state_t
//  Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int NREQ            = 4;
    localparam int REQ_IDX_W       = 2;
    localparam int TIMEOUT_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_rr_arbiter_rr_pick4.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick4
//  Purpose  : Combinational round-robin picker. Returns the first set request
//             bit searching ptr+1, ptr+2, ... (mod NREQ); ptr itself is the
//             last candidate considered.
//  Ports    : req   in  [NREQ-1:0]       request vector
//             ptr   in  [REQ_IDX_W-1:0]  index of the previous winner
//             valid out                  any request present
//             idx   out [REQ_IDX_W-1:0]  selected requester
//  Revision : 1.0 - initial release
// ============================================================================
module rr_pick4
    import mem_arb_pkg::*;
(
    input  logic [NREQ-1:0]      req,
    input  logic [REQ_IDX_W-1:0] ptr,
    output logic                 valid,
    output logic [REQ_IDX_W-1:0] idx
);

    always_comb begin
        valid = |req;
        idx   = ptr;
        // Scan from the farthest candidate back to the nearest so the last
        // assignment, i.e. the nearest set bit after ptr, is the one kept.
        for (int off = NREQ; off >= 1; off--) begin
            if (req[ptr + REQ_IDX_W'(off)]) begin
                idx = ptr + REQ_IDX_W'(off);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_rr_arbiter
//  Purpose  : Round-robin arbiter sharing one memory port between four
//             requesters (fetch, decode, execute, writeback). The winner's
//             direction, address and write data are latched at grant; the
//             arbiter runs the en/read/write/ready handshake and returns
//             registered read data plus a one-cycle done pulse.
//  Options  : MEM_RR_ARBITER_TIMEOUT_EN - when defined, WAIT is bounded to
//             TIMEOUT cycles; on expiry done and err pulse together and the
//             requester's rdata is left unchanged. When undefined, WAIT is
//             unbounded and err is tied to 0.
//  Ports    : clk, reset_n (async assert, active low)
//             req/we [4]             per-requester request and direction
//             addr/wdata [4*W]       requester i at [i*W +: W]
//             rdata [4*DATA_W]       registered read data per requester
//             done/err [4]           one-cycle completion / timeout pulses
//             busy, grant_id         status
//             mem_* / mem_ready      memory handshake
//  Revision : 1.0 - initial release
// ============================================================================
module mem_rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        we,
    input  logic [NREQ*ADDR_W-1:0] addr,
    input  logic [NREQ*DATA_W-1:0] wdata,
    output logic [NREQ*DATA_W-1:0] rdata,
    output logic [NREQ-1:0]        done,
    output logic [NREQ-1:0]        err,
    output logic                   busy,
    output logic [REQ_IDX_W-1:0]   grant_id,
    output logic                   mem_en,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic [ADDR_W-1:0]      mem_address,
    output logic [DATA_W-1:0]      mem_input_data,
    input  logic [DATA_W-1:0]      mem_output_data,
    input  logic                   mem_ready
);

    arb_state_t             state_q, state_d;
    logic [REQ_IDX_W-1:0]   rr_ptr_q;
    logic [REQ_IDX_W-1:0]   grant_id_q;
    logic                   we_q;
    logic [ADDR_W-1:0]      addr_q;
    logic [DATA_W-1:0]      wdata_q;

    logic                   pick_valid;
    logic [REQ_IDX_W-1:0]   pick_idx;
    logic                   load;
    logic                   capture;
    logic                   in_wait;
    logic                   in_done;

`ifdef MEM_RR_ARBITER_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;
`endif

    rr_pick4 u_pick (
        .req   (req),
        .ptr   (rr_ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        capture = 1'b0;
`ifdef MEM_RR_ARBITER_TIMEOUT_EN
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = WAIT;
                    load    = 1'b1;
`ifdef MEM_RR_ARBITER_TIMEOUT_EN
                    cnt_d   = '0;
                    tmo_d   = 1'b0;
`endif
                end
            end
            WAIT: begin
                if (mem_ready) begin
                    state_d = DONE;
                    capture = ~we_q;
                end
`ifdef MEM_RR_ARBITER_TIMEOUT_EN
                // A ready arriving on the last allowed cycle still completes normally.
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = DONE;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, pointer and latched-request registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            // Previous winner = last index, so requester 0 is first in line.
            rr_ptr_q   <= REQ_IDX_W'(NREQ - 1);
            grant_id_q <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                rr_ptr_q   <= pick_idx;
                grant_id_q <= pick_idx;
                we_q       <= we[pick_idx];
                addr_q     <= addr[pick_idx*ADDR_W +: ADDR_W];
                wdata_q    <= wdata[pick_idx*DATA_W +: DATA_W];
            end
        end
    end

`ifdef MEM_RR_ARBITER_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end
`else
    // TIMEOUT has no effect while the bounded-wait feature is compiled out.
    if (TIMEOUT < 0) begin : g_timeout_unused
    end
`endif

    // ------------------------------------------------------------------
    // Outputs: decoded from registered state so that an asynchronous reset
    // drops the memory lines and busy at once.
    // ------------------------------------------------------------------
    assign in_wait        = (state_q == WAIT);
    assign in_done        = (state_q == DONE);
    assign busy           = (state_q != IDLE);
    assign grant_id       = grant_id_q;
    assign mem_en         = in_wait;
    assign mem_read       = in_wait & ~we_q;
    assign mem_write      = in_wait &  we_q;
    assign mem_address    = in_wait ? addr_q  : '0;
    assign mem_input_data = in_wait ? wdata_q : '0;

    for (genvar i = 0; i < NREQ; i++) begin : g_req
        logic [DATA_W-1:0] rdata_q;
        logic              is_winner;

        assign is_winner = (grant_id_q == REQ_IDX_W'(i));

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                rdata_q <= '0;
            end else if (capture && is_winner) begin
                rdata_q <= mem_output_data;
            end
        end

        assign rdata[i*DATA_W +: DATA_W] = rdata_q;
        assign done[i]                   = in_done & is_winner;
`ifdef MEM_RR_ARBITER_TIMEOUT_EN
        assign err[i]                    = in_done & is_winner & tmo_q;
`else
        assign err[i]                    = 1'b0;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_rr_arbiter
//  Purpose  : Directed self-checking bench for mem_rr_arbiter with a small
//             behavioural memory (programmable latency, stall control).
//             Covers reset, single read/write, contention fairness, pointer
//             wrap, reset mid-WAIT and bounded/unbounded WAIT depending on
//             MEM_RR_ARBITER_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_rr_arbiter;

    localparam int AW = 8;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [3:0]      req;
    logic [3:0]      we;
    logic [4*AW-1:0] addr;
    logic [4*DW-1:0] wdata;
    logic [4*DW-1:0] rdata;
    logic [3:0]      done;
    logic [3:0]      err;
    logic            busy;
    logic [1:0]      grant_id;
    logic            mem_en, mem_read, mem_write;
    logic [AW-1:0]   mem_address;
    logic [DW-1:0]   mem_input_data;
    logic [DW-1:0]   mem_output_data;
    logic            mem_ready;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_rr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(16)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .req             (req),
        .we              (we),
        .addr            (addr),
        .wdata           (wdata),
        .rdata           (rdata),
        .done            (done),
        .err             (err),
        .busy            (busy),
        .grant_id        (grant_id),
        .mem_en          (mem_en),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_input_data  (mem_input_data),
        .mem_output_data (mem_output_data),
        .mem_ready       (mem_ready)
    );

    // Behavioural memory: responds lat cycles after mem_en rises, driven
    // on the falling edge so the DUT sees stable inputs at the rising edge.
    logic [7:0] mem [256];
    int         lat   = 2;
    bit         stall = 1'b0;
    int         wcnt  = 0;
    logic       mrdy  = 1'b0;
    logic [7:0] mout  = 8'h00;

    assign mem_ready       = mrdy;
    assign mem_output_data = mout;

    always @(negedge clk) begin
        if (!mem_en) begin
            mrdy = 1'b0;
            wcnt = 0;
        end else if (!mrdy && !stall) begin
            wcnt++;
            if (wcnt >= lat) begin
                mrdy = 1'b1;
                if (mem_write) mem[mem_address] = mem_input_data;
                else           mout = mem[mem_address];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done === 4'b0000 && n < 64) begin
            tick();
            n++;
        end
        check("done_seen", {31'b0, (done !== 4'b0000)}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[8'h10] = 8'hA5;

        // ---------------- reset ----------------
        reset_n = 1'b0;
        req = '0; we = '0; addr = '0; wdata = '0;
        repeat (3) tick();
        check("rst_busy",  {31'b0, busy},     32'd0);
        check("rst_mem",   {29'b0, mem_en, mem_read, mem_write}, 32'd0);
        check("rst_done",  {28'b0, done},     32'd0);
        check("rst_err",   {28'b0, err},      32'd0);
        check("rst_grant", {30'b0, grant_id}, 32'd0);
        check("rst_rdata", rdata,             32'd0);
        reset_n = 1'b1;
        tick();

        // ---------------- single read, requester 0 ----------------
        addr[7:0] = 8'h10;
        req = 4'b0001;
        tick();
        check("rd_en",    {29'b0, mem_en, mem_read, mem_write}, 32'b110);
        check("rd_addr",  {24'b0, mem_address}, 32'h10);
        check("rd_grant", {30'b0, grant_id},    32'd0);
        check("rd_busy",  {31'b0, busy},        32'd1);
        tick();
        check("rd_wait2", {28'b0, done, mem_read}, 32'b00001);
        tick();
        check("rd_done",  {28'b0, done},        32'b0001);
        check("rd_lines", {29'b0, mem_en, mem_read, mem_write}, 32'd0);
        check("rd_data",  {24'b0, rdata[7:0]},  32'hA5);
        req = 4'b0000;
        tick();
        check("rd_idle",  {27'b0, busy, done},  32'd0);

        // ---------------- single write, requester 2 ----------------
        req = 4'b0100; we = 4'b0100;
        addr[23:16] = 8'h20; wdata[23:16] = 8'h3C;
        tick();
        check("wr_lines", {29'b0, mem_en, mem_read, mem_write}, 32'b101);
        check("wr_addr",  {24'b0, mem_address},    32'h20);
        check("wr_data",  {24'b0, mem_input_data}, 32'h3C);
        check("wr_grant", {30'b0, grant_id},       32'd2);
        wait_done(n);
        check("wr_lat",   n, 32'd2);
        check("wr_done",  {28'b0, done}, 32'b0100);
        check("wr_din0",  {24'b0, mem_input_data}, 32'h00);
        req = 4'b0000; we = 4'b0000;
        tick();
        check("wr_mem",   {24'b0, mem[8'h20]}, 32'h3C);

        // read back through requester 3 (leaves pointer at 3)
        addr[31:24] = 8'h20;
        req = 4'b1000;
        tick();
        check("rb_grant", {30'b0, grant_id}, 32'd3);
        wait_done(n);
        check("rb_done",  {28'b0, done}, 32'b1000);
        check("rb_data",  {24'b0, rdata[31:24]}, 32'h3C);
        req = 4'b0000;
        tick();

        // ---------------- contention: all four requesting ----------------
        lat  = 1;
        addr = {8'h33, 8'h32, 8'h31, 8'h30};
        req  = 4'b1111;
        for (int t = 0; t < 8; t++) begin
            wait_done(n);
            check($sformatf("cont_grant%0d", t), {30'b0, grant_id}, 32'(t % 4));
            check($sformatf("cont_done%0d", t),  {28'b0, done},     32'(1 << (t % 4)));
            if (t == 7) req = 4'b0000;
            tick();
        end
        check("cont_rdata", rdata, {8'h69, 8'h68, 8'h6B, 8'h6A});

        // ---------------- pointer wrap: last grant 3, req 1001 ----------------
        req = 4'b1001;
        wait_done(n);
        check("wrap_g0", {30'b0, grant_id}, 32'd0);
        check("wrap_d0", {28'b0, done},     32'b0001);
        tick();
        wait_done(n);
        check("wrap_g3", {30'b0, grant_id}, 32'd3);
        check("wrap_d3", {28'b0, done},     32'b1000);
        req = 4'b0000;
        tick();

        // ---------------- reset while in WAIT ----------------
        stall = 1'b1;
        req   = 4'b0010;
        tick();
        check("mr_grant", {30'b0, grant_id}, 32'd1);
        check("mr_en",    {31'b0, mem_en},   32'd1);
        repeat (2) tick();
        reset_n = 1'b0;
        #1;
        check("mr_lines", {29'b0, mem_en, mem_read, mem_write}, 32'd0);
        check("mr_busy",  {31'b0, busy},  32'd0);
        check("mr_done",  {28'b0, done},  32'd0);
        check("mr_rdata", rdata,          32'd0);
        req   = 4'b0011;
        stall = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        check("mr_next",  {30'b0, grant_id}, 32'd0);
        wait_done(n);
        check("mr_ndone", {28'b0, done}, 32'b0001);
        check("mr_ndata", {24'b0, rdata[7:0]}, 32'h6A);
        req = 4'b0000;
        tick();

        // ---------------- memory never answers ----------------
        stall = 1'b1;
        req   = 4'b0001;
        tick();
`ifdef MEM_RR_ARBITER_TIMEOUT_EN
        repeat (15) tick();
        check("to_wait16", {27'b0, busy, done}, 32'b10000);
        tick();
        check("to_done",  {28'b0, done}, 32'b0001);
        check("to_err",   {28'b0, err},  32'b0001);
        check("to_lines", {31'b0, mem_en}, 32'd0);
        check("to_rdata", {24'b0, rdata[7:0]}, 32'h6A);
        req   = 4'b0000;
        stall = 1'b0;
        tick();
        check("to_after", {27'b0, busy, err}, 32'd0);
`else
        repeat (20) tick();
        check("nt_busy", {30'b0, busy, mem_en}, 32'b11);
        check("nt_done", {24'b0, done, err},    32'd0);
        stall = 1'b0;
        wait_done(n);
        check("nt_fin",  {24'b0, done, err},    32'b00010000);
        req = 4'b0000;
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
